// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared pipelined 8-bit adder: grants one
// requester per cycle, registers its operands and returns the tagged result.
module adder_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 2,
  parameter int ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  input  logic [7:0]             add_sum,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [7:0]             rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int              DEPTH   = ADD_LATENCY + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("adder_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (ADD_LATENCY < 1) begin : g_bad_latency
    $error("adder_arbiter: ADD_LATENCY must be at least 1");
  end

  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [7:0]                  add_a_q, add_a_d;
  logic [7:0]                  add_b_q, add_b_d;
  logic [DEPTH-1:0]            tag_vld_q;
  logic [DEPTH-1:0][ID_W-1:0]  tag_id_q;
  logic                        rsp_valid_q;
  logic [ID_W-1:0]             rsp_id_q;
  logic [7:0]                  rsp_sum_q;
  logic                        rsp_cout_q;

  logic [NUM_REQ-1:0]          upper_mask;
  logic [NUM_REQ-1:0]          masked_req;
  logic [NUM_REQ-1:0]          pick_vec;
  logic [ID_W-1:0]             gnt_id;
  logic                        hs;
  logic [7:0]                  a_sel, b_sel;

  // Requesters at or above the pointer win first; if none are valid the
  // search wraps to the lowest-indexed valid requester.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    upper_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      upper_mask[j] = (ID_W'(j) >= ptr_q);
    end
    masked_req = req_valid & upper_mask;
    pick_vec   = (|masked_req) ? masked_req : req_valid;

    gnt_id = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (pick_vec[j]) gnt_id = ID_W'(j);
    end

    hs = (|req_valid) & ~rst;

    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = hs & (gnt_id == ID_W'(j));
      if (gnt_id == ID_W'(j)) begin
        a_sel = req_a[8*j +: 8];
        b_sel = req_b[8*j +: 8];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (hs) begin
      ptr_d   = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
      add_a_d = a_sel;
      add_b_d = b_sel;
    end
  end

  // The tag pipeline is one stage longer than the adder so the response
  // register captures add_sum on the edge after it becomes valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      tag_vld_q   <= {tag_vld_q[DEPTH-2:0], hs};
      tag_id_q    <= {tag_id_q[DEPTH-2:0], gnt_id};
      rsp_valid_q <= tag_vld_q[DEPTH-1];
      rsp_id_q    <= tag_id_q[DEPTH-1];
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a two-stage behavioural adder model
// and a response monitor that records every rsp_valid pulse.
module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int sum;
    int cout;
    int cyc;
  } rsp_t;
  rsp_t rsp_q[$];

  adder_arbiter #(.NUM_REQ(4), .ADD_LATENCY(2), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-edge adder: result valid two edges after operands settle.
  logic [8:0] s1, s2;
  always @(posedge clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b};
    s2 <= s1;
  end
  assign add_sum  = s2[7:0];
  assign add_cout = s2[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back('{int'(rsp_id), int'(rsp_sum), int'(rsp_cout), cyc});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
  endtask

  task automatic check_rsp(input string tag, input int k, input int id, input int sum, input int cout);
    if (rsp_q.size() <= k) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      check({tag, "_id"},   rsp_q[k].id,   id);
      check({tag, "_sum"},  rsp_q[k].sum,  sum);
      check({tag, "_cout"}, rsp_q[k].cout, cout);
    end
  endtask

  logic [3:0] exp_g[5];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    step(2);

    // Reset state, including no grant while rst is high.
    req_valid = 4'b1111;
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request: 10 + 20 from requester 0.
    req_valid = 4'b0001;
    set_op(0, 8'd10, 8'd20);
    #1;
    check("single_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("single_add_a", add_a, 10);
    check("single_add_b", add_b, 20);
    check("single_busy0", busy, 1);
    check("single_rv0", rsp_valid, 0);
    step();
    check("single_busy1", busy, 1);
    step();
    check("single_busy2", busy, 1);
    check("single_rv2", rsp_valid, 0);
    step();
    check("single_rv3", rsp_valid, 1);
    check("single_id", rsp_id, 0);
    check("single_sum", rsp_sum, 30);
    check("single_cout", rsp_cout, 0);
    check("single_busy3", busy, 0);
    step();
    check("single_rv4", rsp_valid, 0);

    // All four valid from reset: grants 0,1,2,3,0 back to back.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_q.delete();
    for (int i = 0; i < 4; i++) set_op(i, 8'(10 * (i + 1)), 8'(i + 1));
    req_valid = 4'b1111;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), req_ready, exp_g[k]);
      step();
    end
    req_valid = '0;
    step(6);
    check("rr_count", rsp_q.size(), 5);
    check_rsp("rr0", 0, 0, 11, 0);
    check_rsp("rr1", 1, 1, 22, 0);
    check_rsp("rr2", 2, 2, 33, 0);
    check_rsp("rr3", 3, 3, 44, 0);
    check_rsp("rr4", 4, 0, 11, 0);
    if (rsp_q.size() == 5) check("rr_no_gap", rsp_q[4].cyc - rsp_q[0].cyc, 4);

    // Carry cases on requester 2.
    rsp_q.delete();
    req_valid = 4'b0100;
    set_op(2, 8'd255, 8'd1);
    #1;
    check("carry_ready0", req_ready, 4'b0100);
    step();
    set_op(2, 8'd255, 8'd255);
    #1;
    check("carry_ready1", req_ready, 4'b0100);
    step();
    set_op(2, 8'd100, 8'd100);
    #1;
    check("carry_ready2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step(6);
    check("carry_count", rsp_q.size(), 3);
    check_rsp("c255p1", 0, 2, 0, 1);
    check_rsp("c255p255", 1, 2, 254, 1);
    check_rsp("c100p100", 2, 2, 200, 0);

    // Sparse fairness: 1010 held from pointer 0 -> 1, 3, 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_q.delete();
    set_op(1, 8'd1, 8'd1);
    set_op(3, 8'd2, 8'd2);
    req_valid = 4'b1010;
    exp_g[0] = 4'b0010;
    exp_g[1] = 4'b1000;
    exp_g[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("fair_grant%0d", k), req_ready, exp_g[k]);
      step();
    end
    req_valid = '0;
    step(6);
    check("fair_count", rsp_q.size(), 3);
    check_rsp("fair0", 0, 1, 2, 0);
    check_rsp("fair1", 1, 3, 4, 0);
    check_rsp("fair2", 2, 1, 2, 0);

    // Reset with two operations in flight (pointer is 2 beforehand).
    rsp_q.delete();
    req_valid = 4'b0001;
    set_op(0, 8'd1, 8'd2);
    #1;
    check("mid_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    set_op(1, 8'd3, 8'd4);
    #1;
    check("mid_ready1", req_ready, 4'b0010);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    check("mid_busy", busy, 0);
    check("mid_add_a", add_a, 0);
    check("mid_add_b", add_b, 0);
    check("mid_rv", rsp_valid, 0);
    rst = 1'b0;
    step(5);
    check("mid_no_rsp", rsp_q.size(), 0);
    for (int i = 0; i < 4; i++) set_op(i, 8'd50, 8'd50);
    set_op(0, 8'd7, 8'd8);
    req_valid = 4'b1111;
    #1;
    check("mid_ptr0_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step(5);
    check("mid_post_count", rsp_q.size(), 1);
    check_rsp("mid_post", 0, 0, 15, 0);

    // Idle gaps: pointer is 1 here and must survive four idle cycles.
    rsp_q.delete();
    set_op(1, 8'd5, 8'd6);
    req_valid = 4'b0010;
    #1;
    check("idle_ready0", req_ready, 4'b0010);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("idle_nogrant%0d", k), req_ready, 4'b0000);
      check($sformatf("idle_add_a%0d", k), add_a, 5);
      check($sformatf("idle_add_b%0d", k), add_b, 6);
      step();
    end
    set_op(2, 8'd9, 8'd9);
    req_valid = 4'b1111;
    #1;
    check("idle_ready1", req_ready, 4'b0100);
    step();
    req_valid = '0;
    check("idle_add_a_new", add_a, 9);
    step(6);
    check("idle_count", rsp_q.size(), 2);
    check_rsp("idle0", 0, 1, 11, 0);
    check_rsp("idle1", 1, 2, 18, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
